// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings and helpers for the byte-wide memory controller
package mem_ctrl_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_RD   = 2'd1;
    localparam logic [1:0] ST_MEM_WR   = 2'd2;
    localparam logic [1:0] ST_MEM_DONE = 2'd3;

    // Width code 11 is a word access.
    function automatic logic [2:0] bytes_for_width(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            WIDTH_WORD: return 3'd4;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_byte_lane.sv
// rtl/mem_ctrl_byte_lane.sv - store byte select, load byte insert and sign/zero fill
module mem_ctrl_byte_lane
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  idx,
    input  logic [1:0]  width,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] acc,
    input  byte_t       din,
    output byte_t       wbyte,
    output logic [31:0] acc_next,
    output logic [31:0] filled
);

    always_comb begin
        wbyte    = wdata[8*idx +: 8];
        acc_next = acc;
        acc_next[8*idx +: 8] = din;
        case (width)
            WIDTH_BYTE: filled = {{24{sext & acc_next[7]}}, acc_next[7:0]};
            WIDTH_HALF: filled = {{16{sext & acc_next[15]}}, acc_next[15:0]};
            default:    filled = acc_next;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM port owner arbitrating IF fetches and MEM byte bursts
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [7:0]        if_byte_o,
    output logic              if_busy_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_width_i,
    input  logic              mem_sext_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    logic [1:0]        state;
    logic [2:0]        k;
    logic [2:0]        n_bytes;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        width_q;
    logic              sext_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;
    logic [31:0]       rdata_q;
    logic [1:0]        lane_idx;
    byte_t             lane_wbyte;
    logic [31:0]       acc_next;
    logic [31:0]       filled;

    // IF reads are side-effect free, so the request qualifier is not needed.
    logic unused_if_req;
    assign unused_if_req = if_req_i;

    assign n_bytes = bytes_for_width(width_q);
    // Load bytes land one cycle after their address, so the insert lane trails k.
    assign lane_idx = (state == ST_MEM_RD) ? 2'(k - 3'd1) : k[1:0];

    mem_ctrl_byte_lane u_lane (
        .idx      (lane_idx),
        .width    (width_q),
        .sext     (sext_q),
        .wdata    (wdata_q),
        .acc      (acc_q),
        .din      (ram_din_i),
        .wbyte    (lane_wbyte),
        .acc_next (acc_next),
        .filled   (filled)
    );

    assign if_byte_o   = ram_din_i;
    assign if_busy_o   = mem_req_i | (state != ST_IDLE);
    assign mem_done_o  = (state == ST_MEM_DONE);
    assign stall_req_o = (mem_req_i & ~mem_done_o) | (state != ST_IDLE);
    assign mem_rdata_o = rdata_q;

    always_comb begin
        ram_a_o    = if_addr_i;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'h00;
        case (state)
            ST_MEM_RD: ram_a_o = addr_q + ADDR_W'(k);
            ST_MEM_WR: begin
                ram_a_o    = addr_q + ADDR_W'(k);
                ram_wr_o   = 1'b1;
                ram_dout_o = lane_wbyte;
            end
            ST_MEM_DONE: ram_a_o = addr_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            k       <= 3'd0;
            addr_q  <= '0;
            width_q <= WIDTH_BYTE;
            sext_q  <= 1'b0;
            wdata_q <= 32'h0;
            acc_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        addr_q  <= mem_addr_i;
                        width_q <= mem_width_i;
                        sext_q  <= mem_sext_i & ~mem_we_i;
                        wdata_q <= mem_wdata_i;
                        k       <= 3'd0;
                        acc_q   <= 32'h0;
                        state   <= mem_we_i ? ST_MEM_WR : ST_MEM_RD;
                    end
                end
                ST_MEM_RD: begin
                    if (k != 3'd0) acc_q <= acc_next;
                    if (k == n_bytes) begin
                        rdata_q <= filled;
                        state   <= ST_MEM_DONE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                ST_MEM_WR: begin
                    if (k == n_bytes - 3'd1) state <= ST_MEM_DONE;
                    else                     k     <= k + 3'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        if_req;
    logic [31:0] if_addr;
    logic [7:0]  if_byte;
    logic        if_busy;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic        mem_sext;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_req;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            ram[10'h000] <= 8'h55;
            ram[10'h3FF] <= 8'hAA;
            ram[10'h100] <= 8'h13;
            ram[10'h101] <= 8'h05;
            ram[10'h200] <= 8'h78;
            ram[10'h201] <= 8'h56;
            ram[10'h202] <= 8'h34;
            ram[10'h203] <= 8'h12;
            ram[10'h010] <= 8'h80;
            ram[10'h020] <= 8'h01;
            ram[10'h021] <= 8'h80;
            ram_din <= 8'h00;
        end else begin
            if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
            ram_din <= ram[ram_a[9:0]];
        end
    end

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_byte_o   (if_byte),
        .if_busy_o   (if_busy),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_width_i (mem_width),
        .mem_sext_i  (mem_sext),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .stall_req_o (stall_req),
        .ram_a_o     (ram_a),
        .ram_wr_o    (ram_wr),
        .ram_dout_o  (ram_dout),
        .ram_din_i   (ram_din)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load: addresses for nb cycles, one capture cycle, then the done cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] width,
                           input logic sext, input int nb, input logic [31:0] exp_data);
        logic [31:0] ea;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_width = width;
        mem_sext  = sext;
        mem_addr  = addr;
        #1;
        chk({tag, " busy_at_req"}, 32'(if_busy), 32'd1);
        chk({tag, " stall_at_req"}, 32'(stall_req), 32'd1);
        for (int c = 1; c <= nb + 2; c++) begin
            @(negedge clk);
            if (c <= nb) begin
                ea = addr + 32'(c - 1);
                chk($sformatf("%s ram_a c%0d", tag, c), ram_a, ea);
                chk($sformatf("%s ram_wr c%0d", tag, c), 32'(ram_wr), 32'd0);
            end
            if (c <= nb + 1) begin
                chk($sformatf("%s done_early c%0d", tag, c), 32'(mem_done), 32'd0);
            end else begin
                chk({tag, " done"}, 32'(mem_done), 32'd1);
                chk({tag, " rdata"}, mem_rdata, exp_data);
                chk({tag, " stall_in_done"}, 32'(stall_req), 32'd1);
            end
        end
        mem_req = 1'b0;
        @(negedge clk);
        chk({tag, " busy_after"}, 32'(if_busy), 32'd0);
        chk({tag, " stall_after"}, 32'(stall_req), 32'd0);
        chk({tag, " done_after"}, 32'(mem_done), 32'd0);
    endtask

    logic [7:0] if_exp [0:3];

    initial begin
        if_exp[0] = 8'h13; if_exp[1] = 8'h05; if_exp[2] = 8'h00; if_exp[3] = 8'h00;
        rst = 1'b1; preload = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_width = 2'b00; mem_sext = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst ram_wr", 32'(ram_wr), 32'd0);
        chk("rst ram_a", ram_a, 32'h0);
        chk("rst ram_dout", 32'(ram_dout), 32'h0);
        chk("rst rdata", mem_rdata, 32'h0);
        chk("rst done", 32'(mem_done), 32'd0);
        chk("rst stall", 32'(stall_req), 32'd0);
        chk("rst busy", 32'(if_busy), 32'd0);
        chk("rst if_byte", 32'(if_byte), 32'h0);
        rst = 1'b0; preload = 1'b0;

        // IF byte stream
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = 32'h100 + 32'(i);
            #1;
            chk($sformatf("if ram_a %0d", i), ram_a, 32'h100 + 32'(i));
            chk($sformatf("if busy %0d", i), 32'(if_busy), 32'd0);
            @(negedge clk);
            chk($sformatf("if byte %0d", i), 32'(if_byte), 32'(if_exp[i]));
        end
        if_req = 1'b0;

        do_load("ld_word", 32'h200, 2'b10, 1'b0, 4, 32'h12345678);
        do_load("ld_byte_sx", 32'h10, 2'b00, 1'b1, 1, 32'hFFFFFF80);
        do_load("ld_byte_zx", 32'h10, 2'b00, 1'b0, 1, 32'h00000080);
        do_load("ld_half_sx", 32'h20, 2'b01, 1'b1, 2, 32'hFFFF8001);
        do_load("ld_width11", 32'h200, 2'b11, 1'b1, 4, 32'h12345678);
        do_load("ld_wrap", 32'hFFFFFFFF, 2'b01, 1'b1, 2, 32'h000055AA);

        // Store half
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b01; mem_sext = 1'b1;
        mem_addr = 32'h300; mem_wdata = 32'h1234BEEF;
        #1;
        chk("st busy_at_req", 32'(if_busy), 32'd1);
        @(negedge clk);
        chk("st c1 wr", 32'(ram_wr), 32'd1);
        chk("st c1 a", ram_a, 32'h300);
        chk("st c1 dout", 32'(ram_dout), 32'hEF);
        chk("st c1 busy", 32'(if_busy), 32'd1);
        chk("st c1 done", 32'(mem_done), 32'd0);
        @(negedge clk);
        chk("st c2 wr", 32'(ram_wr), 32'd1);
        chk("st c2 a", ram_a, 32'h301);
        chk("st c2 dout", 32'(ram_dout), 32'hBE);
        chk("st c2 done", 32'(mem_done), 32'd0);
        @(negedge clk);
        chk("st done", 32'(mem_done), 32'd1);
        chk("st done wr", 32'(ram_wr), 32'd0);
        chk("st done busy", 32'(if_busy), 32'd1);
        mem_req = 1'b0;
        @(negedge clk);
        chk("st ram300", 32'(ram[10'h300]), 32'hEF);
        chk("st ram301", 32'(ram[10'h301]), 32'hBE);
        chk("st ram302", 32'(ram[10'h302]), 32'h00);
        chk("st busy_after", 32'(if_busy), 32'd0);

        // MEM preempts an IF stream, IF re-requests afterwards
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("pre if byte0", 32'(if_byte), 32'h13);
        if_addr = 32'h101;
        do_load("pre_ld", 32'h10, 2'b00, 1'b0, 1, 32'h00000080);
        chk("pre if ram_a", ram_a, 32'h101);
        @(negedge clk);
        chk("pre if byte1", 32'(if_byte), 32'h05);
        if_req = 1'b0;

        // Reset during a word store after byte 1
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_sext = 1'b0;
        mem_addr = 32'h340; mem_wdata = 32'hDDCCBBAA;
        @(negedge clk);
        chk("rst_st c1 dout", 32'(ram_dout), 32'hAA);
        chk("rst_st c1 a", ram_a, 32'h340);
        @(negedge clk);
        chk("rst_st c2 dout", 32'(ram_dout), 32'hBB);
        chk("rst_st c2 wr", 32'(ram_wr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_st wr", 32'(ram_wr), 32'd0);
        chk("rst_st done", 32'(mem_done), 32'd0);
        chk("rst_st rdata", mem_rdata, 32'h0);
        rst = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        chk("rst_st idle wr", 32'(ram_wr), 32'd0);
        chk("rst_st idle done", 32'(mem_done), 32'd0);
        chk("rst_st idle stall", 32'(stall_req), 32'd0);
        chk("rst_st idle busy", 32'(if_busy), 32'd0);
        chk("rst_st ram342", 32'(ram[10'h342]), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
